// File: rtl/exe_trace_checker.sv
// Trace checker: queues expected vectors (with don't-care masks) and compares them
// against observed execution samples, tracking mismatches, progress and completion.
module exe_trace_checker #(
  parameter int unsigned NUM_OF_CHANNELS   = 2,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned FIFO_DEPTH        = 16,
  parameter int unsigned NUM_OF_LINES      = 0,
  parameter int unsigned PAUSE_ON_MISMATCH = 1,
  parameter int unsigned WILDCARD_COMPARE  = 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  exp_valid,
  output logic                                  exp_ready,
  input  logic [NUM_OF_CHANNELS*DATA_WIDTH-1:0] exp_data,
  input  logic [NUM_OF_CHANNELS*DATA_WIDTH-1:0] exp_mask,
  input  logic                                  exp_last,
  input  logic                                  enable_in,
  input  logic [NUM_OF_CHANNELS*DATA_WIDTH-1:0] data_to_cmp,
  input  logic                                  resume_in,
  output logic                                  stall_out,
  output logic                                  pass1_fail0,
  output logic [NUM_OF_CHANNELS-1:0]            mismatch_map,
  output logic [15:0]                           mismatch_count,
  output logic [31:0]                           line_count,
  output logic                                  underflow,
  output logic                                  all_done
);

  localparam int unsigned W    = NUM_OF_CHANNELS * DATA_WIDTH;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StPaused = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [W-1:0]        data_mem_q [FIFO_DEPTH];
  logic [W-1:0]        mask_mem_q [FIFO_DEPTH];
  logic                last_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                exp_ready_q;
  logic [1:0]          state_q, state_d;
  logic                stall_q, pass_q, underflow_q, done_q;
  logic [NUM_OF_CHANNELS-1:0] map_q, map_cmp;
  logic [15:0]         mcount_q;
  logic [31:0]         lcount_q, line_inc;

  logic                push, cmp, empty_strobe, any_mis, lines_hit, head_last;
  logic [W-1:0]        head_data, head_mask, eff_mask;

  assign push         = exp_valid && exp_ready_q;
  assign cmp          = (state_q == StRun) && enable_in && (cnt_q != '0);
  assign empty_strobe = (state_q == StRun) && enable_in && (cnt_q == '0);

  assign head_data = data_mem_q[rd_ptr_q];
  assign head_mask = mask_mem_q[rd_ptr_q];
  assign head_last = last_mem_q[rd_ptr_q];
  assign eff_mask  = (WILDCARD_COMPARE != 0) ? head_mask : '0;

  always_comb begin
    map_cmp = '0;
    for (int c = 0; c < int'(NUM_OF_CHANNELS); c++) begin
      map_cmp[c] = |((head_data[c*DATA_WIDTH +: DATA_WIDTH] ^
                      data_to_cmp[c*DATA_WIDTH +: DATA_WIDTH]) &
                     ~eff_mask[c*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign any_mis   = |map_cmp;
  assign line_inc  = lcount_q + 32'd1;
  assign lines_hit = (NUM_OF_LINES != 0) && (line_inc == 32'(NUM_OF_LINES));

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, cmp})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Completion outranks the mismatch pause.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (cmp) begin
          if (head_last || lines_hit)                  state_d = StDone;
          else if (any_mis && PAUSE_ON_MISMATCH != 0) state_d = StPaused;
        end
      end
      StPaused: if (resume_in) state_d = StRun;
      StDone:   state_d = StDone;
      default:  state_d = StRun;
    endcase
  end

  // Storage has no reset; writes are gated so reset-cycle pushes are dropped.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      data_mem_q[wr_ptr_q] <= exp_data;
      mask_mem_q[wr_ptr_q] <= exp_mask;
      last_mem_q[wr_ptr_q] <= exp_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      exp_ready_q <= 1'b1;
      state_q     <= StRun;
      stall_q     <= 1'b0;
      pass_q      <= 1'b1;
      map_q       <= '0;
      mcount_q    <= '0;
      lcount_q    <= '0;
      underflow_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (cmp)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q       <= cnt_d;
      exp_ready_q <= (cnt_d != CntW'(FIFO_DEPTH));
      state_q     <= state_d;
      stall_q     <= (state_d == StPaused);
      if (state_d == StDone) done_q <= 1'b1;
      if (empty_strobe) underflow_q <= 1'b1;
      if (cmp) begin
        lcount_q <= line_inc;
        if (any_mis) begin
          map_q  <= map_cmp;
          pass_q <= 1'b0;
          if (mcount_q != 16'hFFFF) mcount_q <= mcount_q + 16'd1;
        end
      end
    end
  end

  assign exp_ready      = exp_ready_q;
  assign stall_out      = stall_q;
  assign pass1_fail0    = pass_q;
  assign mismatch_map   = map_q;
  assign mismatch_count = mcount_q;
  assign line_count     = lcount_q;
  assign underflow      = underflow_q;
  assign all_done       = done_q;

endmodule

// File: tb/tb_exe_trace_checker.sv
// Directed bench for exe_trace_checker: a per-cycle vector table plus hand-written
// sequences for wildcard, FIFO-full, line-limit and reset-while-paused cases.
module tb_exe_trace_checker;

  logic        clk = 1'b0;
  logic        reset_n, exp_valid, exp_last, enable_in, resume_in;
  logic [63:0] exp_data, exp_mask, data_to_cmp;

  logic        a_ready, a_stall, a_pass, a_uf, a_done;
  logic [1:0]  a_map;
  logic [15:0] a_mc;
  logic [31:0] a_lc;
  logic        w_ready, w_stall, w_pass, w_uf, w_done;
  logic [1:0]  w_map;
  logic [15:0] w_mc;
  logic [31:0] w_lc;
  logic        n_ready, n_stall, n_pass, n_uf, n_done;
  logic [1:0]  n_map;
  logic [15:0] n_mc;
  logic [31:0] n_lc;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  exe_trace_checker dut (
    .clk(clk), .reset_n(reset_n), .exp_valid(exp_valid), .exp_ready(a_ready),
    .exp_data(exp_data), .exp_mask(exp_mask), .exp_last(exp_last), .enable_in(enable_in),
    .data_to_cmp(data_to_cmp), .resume_in(resume_in), .stall_out(a_stall),
    .pass1_fail0(a_pass), .mismatch_map(a_map), .mismatch_count(a_mc), .line_count(a_lc),
    .underflow(a_uf), .all_done(a_done)
  );

  exe_trace_checker #(.WILDCARD_COMPARE(0)) dut_nw (
    .clk(clk), .reset_n(reset_n), .exp_valid(exp_valid), .exp_ready(w_ready),
    .exp_data(exp_data), .exp_mask(exp_mask), .exp_last(exp_last), .enable_in(enable_in),
    .data_to_cmp(data_to_cmp), .resume_in(resume_in), .stall_out(w_stall),
    .pass1_fail0(w_pass), .mismatch_map(w_map), .mismatch_count(w_mc), .line_count(w_lc),
    .underflow(w_uf), .all_done(w_done)
  );

  exe_trace_checker #(.NUM_OF_LINES(2)) dut_nl (
    .clk(clk), .reset_n(reset_n), .exp_valid(exp_valid), .exp_ready(n_ready),
    .exp_data(exp_data), .exp_mask(exp_mask), .exp_last(exp_last), .enable_in(enable_in),
    .data_to_cmp(data_to_cmp), .resume_in(resume_in), .stall_out(n_stall),
    .pass1_fail0(n_pass), .mismatch_map(n_map), .mismatch_count(n_mc), .line_count(n_lc),
    .underflow(n_uf), .all_done(n_done)
  );

  typedef struct {
    logic        rst_n;
    logic        ev;
    logic [63:0] ed;
    logic [63:0] em;
    logic        el;
    logic        en;
    logic [63:0] obs;
    logic        res;
    logic        x_ready;
    logic        x_stall;
    logic        x_pass;
    logic [1:0]  x_map;
    logic [15:0] x_mc;
    logic [31:0] x_lc;
    logic        x_uf;
    logic        x_done;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [63:0] pk(input logic [31:0] ir, input logic [31:0] pc);
    return {ir, pc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Apply one cycle of inputs, then sample on the following falling edge.
  task automatic cycle(input logic rst, input logic ev, input logic [63:0] ed,
                       input logic [63:0] em, input logic el, input logic en,
                       input logic [63:0] obs, input logic res);
    reset_n = rst; exp_valid = ev; exp_data = ed; exp_mask = em; exp_last = el;
    enable_in = en; data_to_cmp = obs; resume_in = res;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [63:0] ed, input logic el);
    cycle(1'b1, 1'b1, ed, 64'd0, el, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic strobe(input logic [63:0] obs);
    cycle(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, obs, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ready"}, 32'(a_ready), 32'd1);
    chk({tag, ".stall"}, 32'(a_stall), 32'd0);
    chk({tag, ".pass"},  32'(a_pass),  32'd1);
    chk({tag, ".map"},   32'(a_map),   32'd0);
    chk({tag, ".mcnt"},  32'(a_mc),    32'd0);
    chk({tag, ".lcnt"},  a_lc,         32'd0);
    chk({tag, ".uf"},    32'(a_uf),    32'd0);
    chk({tag, ".done"},  32'(a_done),  32'd0);
  endtask

  function automatic vec_t mk(input logic rst, input logic ev, input logic [63:0] ed,
                              input logic el, input logic en, input logic [63:0] obs,
                              input logic res, input logic st, input logic ps,
                              input logic [1:0] mp, input logic [15:0] mc,
                              input logic [31:0] lc, input logic uf, input logic dn);
    vec_t v;
    v.rst_n = rst; v.ev = ev; v.ed = ed; v.em = 64'd0; v.el = el; v.en = en;
    v.obs = obs; v.res = res; v.x_ready = 1'b1; v.x_stall = st; v.x_pass = ps;
    v.x_map = mp; v.x_mc = mc; v.x_lc = lc; v.x_uf = uf; v.x_done = dn;
    return v;
  endfunction

  initial begin
    reset_n = 1'b1; exp_valid = 1'b0; exp_data = '0; exp_mask = '0; exp_last = 1'b0;
    enable_in = 1'b0; data_to_cmp = '0; resume_in = 1'b0;

    // rst ev data last en obs res | stall pass map mc lc uf done
    vecs[0]  = mk(0, 0, 64'd0,           0, 0, 64'd0,           0, 0, 1, 2'b00, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, pk(32'h13, 'h100), 0, 0, 64'd0,         0, 0, 1, 2'b00, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, pk(32'h13, 'h104), 0, 0, 64'd0,         0, 0, 1, 2'b00, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, pk(32'h13, 'h108), 1, 0, 64'd0,         0, 0, 1, 2'b00, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 64'd0, 0, 1, pk(32'h13, 'h100),         0, 0, 1, 2'b00, 0, 1, 0, 0);
    vecs[5]  = mk(1, 0, 64'd0, 0, 1, pk(32'h13, 'h104),         0, 0, 1, 2'b00, 0, 2, 0, 0);
    vecs[6]  = mk(1, 0, 64'd0, 0, 1, pk(32'h13, 'h108),         0, 0, 1, 2'b00, 0, 3, 0, 1);
    vecs[7]  = mk(1, 0, 64'd0, 0, 1, pk(32'h13, 'h100),         0, 0, 1, 2'b00, 0, 3, 0, 1);
    vecs[8]  = mk(0, 0, 64'd0, 0, 0, 64'd0,                     0, 0, 1, 2'b00, 0, 0, 0, 0);
    vecs[9]  = mk(1, 1, pk(32'h13, 'h200), 0, 0, 64'd0,         0, 0, 1, 2'b00, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, pk(32'h13, 'h204), 0, 0, 64'd0,         0, 0, 1, 2'b00, 0, 0, 0, 0);
    vecs[11] = mk(1, 0, 64'd0, 0, 1, pk(32'h93, 'h200),         0, 1, 0, 2'b10, 1, 1, 0, 0);
    vecs[12] = mk(1, 0, 64'd0, 0, 1, pk(32'h13, 'h204),         0, 1, 0, 2'b10, 1, 1, 0, 0);
    vecs[13] = mk(1, 0, 64'd0, 0, 0, 64'd0,                     1, 0, 0, 2'b10, 1, 1, 0, 0);
    vecs[14] = mk(1, 0, 64'd0, 0, 1, pk(32'h13, 'h204),         0, 0, 0, 2'b10, 1, 2, 0, 0);
    vecs[15] = mk(1, 0, 64'd0, 0, 1, pk(32'h13, 'h204),         0, 0, 0, 2'b10, 1, 2, 1, 0);

    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].rst_n, vecs[i].ev, vecs[i].ed, vecs[i].em, vecs[i].el, vecs[i].en,
            vecs[i].obs, vecs[i].res);
      chk($sformatf("v%0d.ready", i), 32'(a_ready), 32'(vecs[i].x_ready));
      chk($sformatf("v%0d.stall", i), 32'(a_stall), 32'(vecs[i].x_stall));
      chk($sformatf("v%0d.pass", i),  32'(a_pass),  32'(vecs[i].x_pass));
      chk($sformatf("v%0d.map", i),   32'(a_map),   32'(vecs[i].x_map));
      chk($sformatf("v%0d.mcnt", i),  32'(a_mc),    32'(vecs[i].x_mc));
      chk($sformatf("v%0d.lcnt", i),  a_lc,         vecs[i].x_lc);
      chk($sformatf("v%0d.uf", i),    32'(a_uf),    32'(vecs[i].x_uf));
      chk($sformatf("v%0d.done", i),  32'(a_done),  32'(vecs[i].x_done));
    end

    // Wildcard: bit 7 of IR masked
    do_reset();
    cycle(1'b1, 1'b1, pk(32'h13, 32'h300), pk(32'h80, 32'h0), 1'b0, 1'b0, 64'd0, 1'b0);
    strobe(pk(32'h93, 32'h300));
    chk("wc.mcnt",   32'(a_mc),    32'd0);
    chk("wc.pass",   32'(a_pass),  32'd1);
    chk("wc.stall",  32'(a_stall), 32'd0);
    chk("wc.lcnt",   a_lc,         32'd1);
    chk("nowc.mcnt", 32'(w_mc),    32'd1);
    chk("nowc.map",  32'(w_map),   32'd2);
    chk("nowc.stall", 32'(w_stall), 32'd1);
    chk("nowc.pass", 32'(w_pass),  32'd0);

    // FIFO full: push refused while a strobe pops
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(pk(32'h13, 32'(i)), 1'b0);
      if (i == 14) chk("full.ready15", 32'(a_ready), 32'd1);
    end
    chk("full.ready16", 32'(a_ready), 32'd0);
    cycle(1'b1, 1'b1, pk(32'h13, 32'hBAD), 64'd0, 1'b0, 1'b1, pk(32'h13, 32'h0), 1'b0);
    chk("full.ready_after_pop", 32'(a_ready), 32'd1);
    chk("full.lcnt1", a_lc, 32'd1);
    push(pk(32'h13, 32'd16), 1'b0);
    chk("full.ready_refill", 32'(a_ready), 32'd0);
    for (int i = 1; i <= 16; i++) strobe(pk(32'h13, 32'(i)));
    chk("full.lcnt17", a_lc, 32'd17);
    chk("full.mcnt", 32'(a_mc), 32'd0);
    chk("full.uf0", 32'(a_uf), 32'd0);
    strobe(pk(32'h13, 32'd0));
    chk("full.uf1", 32'(a_uf), 32'd1);
    chk("full.lcnt_hold", a_lc, 32'd17);

    // NUM_OF_LINES=2 ends after two compares
    do_reset();
    for (int i = 0; i < 3; i++) push(pk(32'h13, 32'h400 + 32'(i)), 1'b0);
    strobe(pk(32'h13, 32'h400));
    chk("nl.done1", 32'(n_done), 32'd0);
    strobe(pk(32'h13, 32'h401));
    chk("nl.done2", 32'(n_done), 32'd1);
    chk("nl.lcnt2", n_lc, 32'd2);
    strobe(pk(32'h13, 32'h402));
    chk("nl.lcnt3", n_lc, 32'd2);
    chk("nl.uf", 32'(n_uf), 32'd0);
    chk("nl.ref_lcnt", a_lc, 32'd3);
    chk("nl.ref_done", 32'(a_done), 32'd0);

    // Reset while paused with entries queued; reset-cycle push/strobe discarded
    do_reset();
    for (int i = 0; i < 5; i++) push(pk(32'h13, 32'h500 + 32'(i)), 1'b0);
    strobe(pk(32'h93, 32'h500));
    chk("rp.stall", 32'(a_stall), 32'd1);
    cycle(1'b0, 1'b1, pk(32'h13, 32'h600), 64'd0, 1'b0, 1'b1, pk(32'h13, 32'h501), 1'b1);
    chk_reset_vals("rp");
    strobe(pk(32'h13, 32'h600));
    chk("rp.empty_uf", 32'(a_uf), 32'd1);
    chk("rp.empty_lcnt", a_lc, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
